// File: rtl/multiplier_pipe_if.sv
// multiplier_pipe_if: operand/result handshake bundle for multiplier_pipe
interface multiplier_pipe_if #(parameter int WIDTH = 32);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               tc;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] y;
   logic               busy;
   modport master (
      output in_valid, a, b, tc, out_ready,
      input  in_ready, out_valid, y, busy
   );
   modport slave (
      input  in_valid, a, b, tc, out_ready,
      output in_ready, out_valid, y, busy
   );
endinterface

// File: rtl/multiplier_pipe.sv
// multiplier_pipe: STAGES-deep valid/ready multiplier; signed mode enabled by MULTIPLIER_PIPE_SIGNED_EN
module multiplier_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input logic             clk,
   input logic             rst,
   multiplier_pipe_if.slave bus
);
   logic                en;
   logic [STAGES-1:0]   vld_q, vld_d;
   logic [WIDTH-1:0]    a_q, b_q;
   logic [2*WIDTH-1:0]  ea, eb, prod;
   logic [2*WIDTH-1:0]  p_q [1:STAGES-1];
`ifdef MULTIPLIER_PIPE_SIGNED_EN
   logic                tc_q;
`endif
   assign en            = !vld_q[STAGES-1] || bus.out_ready;
   assign bus.in_ready  = en;
   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.y         = p_q[STAGES-1];
   assign bus.busy      = |vld_q;
   // valid bits shift in lockstep; a bubble enters as 0
   always_comb vld_d = en ? {vld_q[STAGES-2:0], bus.in_valid} : vld_q;
   // valid chain register, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else vld_q <= vld_d;
   end
   // stage 1 operand capture; data needs no reset
   always_ff @(posedge clk) begin
      if (en) begin
         a_q <= bus.a;
         b_q <= bus.b;
`ifdef MULTIPLIER_PIPE_SIGNED_EN
         tc_q <= bus.tc;
`endif
      end
   end
   // operand extension to full width so one multiplier serves both modes
   always_comb begin
`ifdef MULTIPLIER_PIPE_SIGNED_EN
      ea = {{WIDTH{tc_q & a_q[WIDTH-1]}}, a_q};
      eb = {{WIDTH{tc_q & b_q[WIDTH-1]}}, b_q};
`else
      ea = {{WIDTH{1'b0}}, a_q};
      eb = {{WIDTH{1'b0}}, b_q};
`endif
      prod = ea * eb;
   end
   // product pipeline; last entry is the output register y, the only data reset
   always_ff @(posedge clk) begin
      if (en) begin
         p_q[1] <= prod;
         for (int s = 2; s < STAGES; s++) p_q[s] <= p_q[s-1];
      end
      if (rst) p_q[STAGES-1] <= '0;
   end
endmodule

// File: tb/tb_multiplier_pipe.sv
// tb_multiplier_pipe: directed checks of latency, stall, order, sign mode and reset
module tb_multiplier_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   multiplier_pipe_if #(.WIDTH(32)) b0 ();
   multiplier_pipe_if #(.WIDTH(8))  b1 ();
   multiplier_pipe #(.WIDTH(32), .STAGES(2)) d0 (.clk(clk), .rst(rst), .bus(b0));
   multiplier_pipe #(.WIDTH(8),  .STAGES(4)) d1 (.clk(clk), .rst(rst), .bus(b1));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
`ifdef MULTIPLIER_PIPE_SIGNED_EN
   localparam logic [63:0] S32 = 64'hFFFF_FFFF_FFFF_FFFE;
   localparam logic [15:0] S8  = 16'hFFFE;
`else
   localparam logic [63:0] S32 = 64'h0000_0001_FFFF_FFFE;
   localparam logic [15:0] S8  = 16'h01FE;
`endif
   initial begin
      {b0.in_valid, b0.a, b0.b, b0.tc, b0.out_ready} = '0;
      {b1.in_valid, b1.a, b1.b, b1.tc, b1.out_ready} = '0;
      b0.out_ready = 1'b1;
      b1.out_ready = 1'b1;
      step();
      step();
      chk("rst_in_ready", b0.in_ready, 1);
      chk("rst_out_valid", b0.out_valid, 0);
      chk("rst_busy", b0.busy, 0);
      chk("rst_y", b0.y, 0);
      rst = 1'b0;
      // max unsigned 32-bit, latency 2
      b0.in_valid = 1'b1; b0.a = 32'hFFFF_FFFF; b0.b = 32'hFFFF_FFFF; b0.tc = 1'b0;
      step();
      b0.a = 32'hFFFF_FFFF; b0.b = 32'h2; b0.tc = 1'b1;
      chk("lat1_out_valid", b0.out_valid, 0);
      chk("lat1_busy", b0.busy, 1);
      step();
      b0.in_valid = 1'b0;
      chk("max_out_valid", b0.out_valid, 1);
      chk("max_y", b0.y, 64'hFFFF_FFFE_0000_0001);
      step();
      chk("s32_out_valid", b0.out_valid, 1);
      chk("s32_y", b0.y, S32);
      step();
      chk("drain_out_valid", b0.out_valid, 0);
      chk("drain_busy", b0.busy, 0);
      // 8-bit sign mode, STAGES=4
      b1.in_valid = 1'b1; b1.a = 8'hFF; b1.b = 8'h02; b1.tc = 1'b1;
      step();
      b1.tc = 1'b0;
      step();
      b1.in_valid = 1'b0;
      step();
      chk("s8_early", b1.out_valid, 0);
      step();
      chk("s8_valid", b1.out_valid, 1);
      chk("s8_y", b1.y, S8);
      step();
      chk("u8_y", b1.y, 16'h01FE);
      step();
      chk("s8_drained", b1.out_valid, 0);
      // back-to-back stream a=i, b=i+1
      for (int k = 1; k <= 14; k++) begin
         b1.in_valid = (k <= 10);
         b1.a = 8'(k - 1);
         b1.b = 8'(k);
         step();
         chk($sformatf("str_valid_%0d", k), b1.out_valid, (k >= 4 && k <= 13));
         if (k >= 4 && k <= 13) chk($sformatf("str_y_%0d", k), b1.y, (k - 4) * (k - 3));
      end
      // fill with out_ready low, stall 5 cycles, then drain
      b1.out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         b1.in_valid = 1'b1; b1.a = 8'(k); b1.b = 8'd3;
         chk($sformatf("fill_ready_%0d", k), b1.in_ready, 1);
         step();
      end
      b1.a = 8'd99;
      for (int k = 0; k < 5; k++) begin
         chk("stall_in_ready", b1.in_ready, 0);
         chk("stall_valid", b1.out_valid, 1);
         chk("stall_y", b1.y, 3);
         step();
      end
      b1.in_valid = 1'b0;
      b1.out_ready = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         step();
         chk($sformatf("rel_valid_%0d", k), b1.out_valid, 1);
         chk($sformatf("rel_y_%0d", k), b1.y, 3 * k);
      end
      step();
      chk("rel_done_valid", b1.out_valid, 0);
      chk("rel_done_busy", b1.busy, 0);
      // reset with 3 entries in flight and an offered operand
      b1.in_valid = 1'b1; b1.a = 8'd5; b1.b = 8'd5;
      for (int k = 0; k < 3; k++) step();
      rst = 1'b1; b1.a = 8'd7; b1.b = 8'd7;
      step();
      rst = 1'b0;
      b1.in_valid = 1'b0;
      chk("mid_rst_valid", b1.out_valid, 0);
      chk("mid_rst_busy", b1.busy, 0);
      chk("mid_rst_y", b1.y, 0);
      chk("mid_rst_ready", b1.in_ready, 1);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("post_rst_stale", b1.out_valid, 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
